// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB receive packet controller.
//   Tracks a packet from its start edge through SYNC check, byte collection
//   and end-of-packet, strobing each received data byte into the RX FIFO.
// Parameters:
//   SYNC_BYTE  expected first byte as assembled LSB-first by the shifter
//   MAX_BYTES  data byte limit per packet (1..127), used by the length check
// Build option:
//   RX_LEN_CHK_EN  when defined, a packet longer than MAX_BYTES is flagged as
//                  an error and the excess byte is not written; otherwise
//                  byte_cnt simply wraps modulo 128.
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   d_edge         line transition pulse (packet start / line back to idle)
//   shift_en       bit sample strobe
//   stuff_bit      current sample is a stuffed bit (not counted)
//   eop            SE0 seen on the current sample
//   rcv_data       parallel shifter contents
//   rcving         packet in progress
//   w_enable       one-cycle FIFO write strobe, rcv_data valid alongside
//   r_error        receive error, held until the next packet start
//   byte_cnt       data bytes written in the current packet
module usb_rx_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_en,
  input  logic       stuff_bit,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [6:0] byte_cnt
);

  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned BYTE_CNT_W = 7;

  if (MAX_BYTES < 1 || MAX_BYTES > 127) begin : g_bad_max_bytes
    $error("usb_rx_ctrl: MAX_BYTES must be in 1..127");
  end

  typedef enum logic [2:0] {
    IDLE,
    SYNC_RX,
    RECV,
    STORE,
    EOP_WAIT,
    ERR_WAIT
  } state_t;

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   byte_done;
  logic                   eop_pend;

  logic                   counting_c;
  logic                   bit_step_c;
  logic                   eop_smp_c;
  logic                   len_full_c;

  assign counting_c = (state == SYNC_RX) || (state == RECV);
  assign bit_step_c = shift_en & ~stuff_bit;
  assign eop_smp_c  = eop & shift_en;

`ifdef RX_LEN_CHK_EN
  // Packet already holds the maximum number of bytes; one more is an overrun.
  assign len_full_c = (byte_cnt == BYTE_CNT_W'(MAX_BYTES));
`else
  assign len_full_c = 1'b0;
`endif

  // Bit counter; held at zero in IDLE so it starts clean in SYNC_RX.
  // byte_done fires the cycle after the 7->0 wrap, once the shifter has
  // taken the eighth bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= counting_c & bit_step_c & (bit_cnt == 3'd7);
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (counting_c && bit_step_c) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Packet FSM with registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rcving   <= 1'b0;
      w_enable <= 1'b0;
      r_error  <= 1'b0;
      byte_cnt <= '0;
      eop_pend <= 1'b0;
    end else begin
      w_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (d_edge) begin
            state    <= SYNC_RX;
            rcving   <= 1'b1;
            r_error  <= 1'b0;
            byte_cnt <= '0;
            eop_pend <= 1'b0;
          end
        end

        SYNC_RX: begin
          if (byte_done) begin
            if (rcv_data == SYNC_BYTE) begin
              state <= RECV;
            end else begin
              state   <= ERR_WAIT;
              r_error <= 1'b1;
            end
          end else if (eop_smp_c) begin
            state   <= ERR_WAIT;
            r_error <= 1'b1;
          end
        end

        RECV: begin
          if (byte_done) begin
            if (len_full_c) begin
              state   <= ERR_WAIT;
              r_error <= 1'b1;
            end else begin
              // An EOP landing with the completed byte is finished after STORE.
              state    <= STORE;
              w_enable <= 1'b1;
              byte_cnt <= byte_cnt + 7'd1;
              eop_pend <= eop_smp_c;
            end
          end else if (eop_smp_c) begin
            if (bit_cnt == '0) begin
              state <= EOP_WAIT;
            end else begin
              state   <= ERR_WAIT;
              r_error <= 1'b1;
            end
          end
        end

        STORE: begin
          eop_pend <= 1'b0;
          state    <= eop_pend ? EOP_WAIT : RECV;
        end

        EOP_WAIT, ERR_WAIT: begin
          if (d_edge) begin
            state  <= IDLE;
            rcving <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
